// File: rtl/parking_occupancy_controller.sv
// Four-slot car park occupancy tracker with sensor edge detection, free-slot count,
// an event strobe and a timed flashing door-open light.
module parking_occupancy_controller #(
    parameter int HALF_PERIOD_CYCLES = 10_000_000,
    parameter int FLASH_TOGGLES      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] switch,
    output logic [3:0] parking_slots,
    output logic [2:0] capacity,
    output logic       full,
    output logic       door_open_pulse,
    output logic       door_open_light
);

    localparam int CNT_W = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
    localparam int TOG_W = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(HALF_PERIOD_CYCLES - 1);
    localparam logic [TOG_W-1:0] TOG_START  = TOG_W'(FLASH_TOGGLES - 1);

    typedef enum logic [0:0] {
        LIGHT_IDLE  = 1'b0,
        LIGHT_FLASH = 1'b1
    } light_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    logic             entry_q_r;
    logic             exit_q_r;
    logic             entry_evt_s;
    logic             exit_evt_s;
    logic [3:0]       slots_next_s;
    logic             pulse_next_s;

    light_state_t     state_r;
    light_state_t     state_next_s;
    logic [CNT_W-1:0] phase_r;
    logic [CNT_W-1:0] phase_next_s;
    logic [TOG_W-1:0] toggles_r;
    logic [TOG_W-1:0] toggles_next_s;
    logic             light_next_s;

    // Rising-edge qualified events; simultaneous sensor activity rejects both.
    assign entry_evt_s = entry_sensor & ~entry_q_r & ~exit_sensor;
    assign exit_evt_s  = exit_sensor  & ~exit_q_r  & ~entry_sensor;

    // Slot update and strobe decision for the current event.
    always_comb begin
        slots_next_s = parking_slots;
        pulse_next_s = 1'b0;
        if (entry_evt_s) begin
            if (!parking_slots[switch]) begin
                slots_next_s[switch] = 1'b1;
                pulse_next_s         = 1'b1;
            end else begin
                pulse_next_s = 1'b0;
            end
        end else if (exit_evt_s) begin
            if (parking_slots[switch]) begin
                slots_next_s[switch] = 1'b0;
                pulse_next_s         = 1'b1;
            end else begin
                pulse_next_s = 1'b0;
            end
        end else begin
            slots_next_s = parking_slots;
        end
    end

    // Occupancy, strobe and sensor history registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            parking_slots   <= 4'b0000;
            door_open_pulse <= 1'b0;
            entry_q_r       <= 1'b0;
            exit_q_r        <= 1'b0;
        end else begin
            parking_slots   <= slots_next_s;
            door_open_pulse <= pulse_next_s;
            entry_q_r       <= entry_sensor;
            exit_q_r        <= exit_sensor;
        end
    end

    assign capacity = 3'd4 - popcount4(parking_slots);
    assign full     = (capacity == 3'd0);

    // Light sequencer next state; a strobe always restarts the sequence.
    always_comb begin
        state_next_s   = state_r;
        phase_next_s   = phase_r;
        toggles_next_s = toggles_r;
        light_next_s   = door_open_light;
        if (door_open_pulse) begin
            state_next_s   = LIGHT_FLASH;
            phase_next_s   = {CNT_W{1'b0}};
            toggles_next_s = TOG_START;
            light_next_s   = 1'b1;
        end else begin
            case (state_r)
                LIGHT_IDLE: begin
                    phase_next_s   = {CNT_W{1'b0}};
                    toggles_next_s = {TOG_W{1'b0}};
                    light_next_s   = 1'b0;
                end
                LIGHT_FLASH: begin
                    if (phase_r == PHASE_LAST) begin
                        phase_next_s = {CNT_W{1'b0}};
                        if (toggles_r == {TOG_W{1'b0}}) begin
                            light_next_s = 1'b0;
                            state_next_s = LIGHT_IDLE;
                        end else begin
                            light_next_s   = ~door_open_light;
                            toggles_next_s = toggles_r - TOG_W'(1);
                        end
                    end else begin
                        phase_next_s = phase_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_next_s = LIGHT_IDLE;
                    light_next_s = 1'b0;
                end
            endcase
        end
    end

    // Light sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= LIGHT_IDLE;
            phase_r         <= {CNT_W{1'b0}};
            toggles_r       <= {TOG_W{1'b0}};
            door_open_light <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            phase_r         <= phase_next_s;
            toggles_r       <= toggles_next_s;
            door_open_light <= light_next_s;
        end
    end

endmodule

// File: tb/tb_parking_occupancy_controller.sv
// Randomized and directed bench for parking_occupancy_controller against a
// behavioural occupancy/light-age reference model.
module tb_parking_occupancy_controller;

    localparam int HP = 4;
    localparam int FT = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] switch;
    logic [3:0] parking_slots;
    logic [2:0] capacity;
    logic       full;
    logic       door_open_pulse;
    logic       door_open_light;

    always #5 clk = ~clk;

    parking_occupancy_controller #(
        .HALF_PERIOD_CYCLES(HP),
        .FLASH_TOGGLES     (FT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entry_sensor   (entry_sensor),
        .exit_sensor    (exit_sensor),
        .switch         (switch),
        .parking_slots  (parking_slots),
        .capacity       (capacity),
        .full           (full),
        .door_open_pulse(door_open_pulse),
        .door_open_light(door_open_light)
    );

    int total = 0;
    int bad   = 0;

    bit occ [4];
    bit m_eq    = 1'b0;
    bit m_xq    = 1'b0;
    bit m_pulse = 1'b0;
    int age     = -1;   // cycles since the light sequence started, -1 when none
    int pulses  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_free();
        int n = 4;
        for (int i = 0; i < 4; i++) if (occ[i]) n--;
        return n;
    endfunction

    function automatic bit model_light();
        return (age >= 0) && (age < HP * FT) && (((age / HP) % 2) == 0);
    endfunction

    task automatic step(input bit e, input bit x, input bit [1:0] sw, input bit rst_n);
        bit prev_pulse;
        bit ev_en;
        bit ev_ex;
        logic [3:0] exp_slots;
        reset        = rst_n;
        entry_sensor = e;
        exit_sensor  = x;
        switch       = sw;
        @(posedge clk);
        prev_pulse = m_pulse;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) occ[i] = 1'b0;
            m_eq = 1'b0; m_xq = 1'b0; m_pulse = 1'b0; age = -1;
        end else begin
            ev_en   = e && !m_eq && !x;
            ev_ex   = x && !m_xq && !e;
            m_pulse = 1'b0;
            if (ev_en && !occ[sw]) begin
                occ[sw] = 1'b1; m_pulse = 1'b1;
            end else if (ev_ex && occ[sw]) begin
                occ[sw] = 1'b0; m_pulse = 1'b1;
            end
            m_eq = e;
            m_xq = x;
            if (prev_pulse) age = 0;
            else if (age >= 0) age++;
        end
        #1;
        for (int i = 0; i < 4; i++) exp_slots[i] = occ[i];
        if (door_open_pulse === 1'b1) pulses++;
        check_val("slots", 32'(parking_slots), 32'(exp_slots));
        check_val("capacity", 32'(capacity), 32'(model_free()));
        check_val("full", 32'(full), 32'(model_free() == 0));
        check_val("pulse", 32'(door_open_pulse), 32'(m_pulse));
        check_val("light", 32'(door_open_light), 32'(model_light()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        step(1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check_val("rst_slots", 32'(parking_slots), 32'h0);
        check_val("rst_cap", 32'(capacity), 32'd4);
        idle(2);

        step(1'b1, 1'b0, 2'd2, 1'b1);
        check_val("ent2_slots", 32'(parking_slots), 32'b0100);
        idle(1);
        step(1'b1, 1'b0, 2'd0, 1'b1);
        check_val("ent0_slots", 32'(parking_slots), 32'b0101);
        check_val("ent0_cap", 32'(capacity), 32'd2);
        idle(1);
        step(1'b1, 1'b0, 2'd1, 1'b1); idle(1);
        step(1'b1, 1'b0, 2'd3, 1'b1); idle(1);
        step(1'b1, 1'b0, 2'd1, 1'b1);
        check_val("full_flag", 32'(full), 32'd1);
        check_val("full_nopulse", 32'(door_open_pulse), 32'd0);
        idle(1);

        step(1'b0, 1'b1, 2'd3, 1'b1);
        check_val("exit3_slots", 32'(parking_slots), 32'b0111);
        idle(1);
        step(1'b0, 1'b1, 2'd3, 1'b1);
        check_val("exit3_again", 32'(door_open_pulse), 32'd0);
        idle(1);
        step(1'b1, 1'b1, 2'd3, 1'b1);
        check_val("both_nopulse", 32'(door_open_pulse), 32'd0);
        idle(1);

        pulses = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'd3, 1'b1);
        check_val("hold_pulses", 32'(pulses), 32'd1);
        idle(30);

        step(1'b0, 1'b1, 2'd0, 1'b1);
        idle(30);
        step(1'b0, 1'b1, 2'd1, 1'b1);
        idle(9);
        step(1'b1, 1'b0, 2'd0, 1'b1);
        idle(30);
        step(1'b0, 1'b1, 2'd2, 1'b1);
        idle(5);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check_val("rst_light", 32'(door_open_light), 32'd0);
        idle(5);

        for (int i = 0; i < 500; i++) begin
            step(($urandom % 3) == 0, ($urandom % 3) == 0, 2'($urandom_range(0, 3)),
                 ($urandom % 60) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
